// File: rtl/dcollide_spheres_stream.sv
// Streaming sphere-sphere narrow-phase collider in signed fixed point Q(W-F).F.
// A single shared multiplier, a bit-serial sqrt and a bit-serial divider produce ODE-style contact data.
module dcollide_spheres_stream #(
  parameter int W            = 32,
  parameter int F            = 16,
  parameter int TAG_W        = 16,
  parameter int CNT_W        = 16,
  parameter int CONTACT_MODE = 0
) (
  input  logic             CLK_d,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     x1,
  input  logic [W-1:0]     y1,
  input  logic [W-1:0]     z1,
  input  logic [W-1:0]     r1,
  input  logic [W-1:0]     x2,
  input  logic [W-1:0]     y2,
  input  logic [W-1:0]     z2,
  input  logic [W-1:0]     r2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic             ret,
  output logic [W-1:0]     cx,
  output logic [W-1:0]     cy,
  output logic [W-1:0]     cz,
  output logic [W-1:0]     normalx,
  output logic [W-1:0]     normaly,
  output logic [W-1:0]     normalz,
  output logic [W-1:0]     depth,
  output logic             busy,
  output logic [CNT_W-1:0] pair_cnt,
  output logic [CNT_W-1:0] hit_cnt
);

  localparam int SW = $clog2(W + 1);
  localparam logic [2*W-1:0] DIV_N = (2*W)'(1) << (2*F);

  typedef enum logic [3:0] {
    S_IDLE, S_DELTA, S_SQ, S_CMP, S_SQRT, S_ZCHK, S_RECIP, S_NORM, S_POS, S_OUT
  } state_t;

  state_t state_reg, state_next;
  logic [SW-1:0] step_reg;
  logic [1:0]    idx;

  logic signed [W-1:0]     p1_reg [3];
  logic signed [W-1:0]     p2_reg [3];
  logic signed [W-1:0]     r1_reg, r2_reg;
  logic signed [W:0]       dlt_reg [4];  // dx, dy, dz, rs
  logic signed [W:0]       rd_reg;
  logic signed [2*W+1:0]   d2_reg, rs2_reg;
  logic [2*W-1:0]          rad_reg;
  logic [W-1:0]            rem_reg, root_reg;
  logic [W-1:0]            dvr_reg, dvn_reg, inv_reg;
  logic signed [W-1:0]     nrm_reg [3];
  logic signed [W-1:0]     pos_reg [3];
  logic signed [W-1:0]     depth_reg;
  logic                    ret_reg, out_valid_reg, in_ready_reg;
  logic [TAG_W-1:0]        out_tag_reg;
  logic [CNT_W-1:0]        pair_cnt_reg, hit_cnt_reg;

  logic signed [W:0]       mul_a, mul_b, k_val;
  logic signed [2*W+1:0]   mul_p;
  logic [W+1:0]            sq_sh, sq_trial;
  logic                    sq_ge;
  logic [W:0]              dv_sh;
  logic                    dv_ge;

  assign idx = step_reg[1:0];

  always_comb begin
    mul_a = '0;
    mul_b = '0;
    case (state_reg)
      S_SQ: begin
        mul_a = dlt_reg[idx];
        mul_b = dlt_reg[idx];
      end
      S_NORM: begin
        mul_a = dlt_reg[idx];
        mul_b = $signed({1'b0, inv_reg});
      end
      S_POS: begin
        mul_a = (W+1)'(nrm_reg[idx]);
        mul_b = k_val;
      end
      default: ;
    endcase
  end

  assign mul_p = (2*W+2)'(mul_a) * (2*W+2)'(mul_b);
  assign k_val = (W+1)'(((W+2)'(rd_reg) - $signed({2'b00, root_reg})) >>> 1);

  // Restoring sqrt: two radicand bits enter the partial remainder per cycle
  assign sq_sh    = {rem_reg, rad_reg[2*W-1 -: 2]};
  assign sq_trial = {root_reg, 2'b01};
  assign sq_ge    = (sq_sh >= sq_trial);

  assign dv_sh = {dvr_reg, dvn_reg[W-1]};
  assign dv_ge = (dv_sh >= {1'b0, root_reg});

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (in_valid && in_ready_reg) state_next = S_DELTA;
      S_DELTA: state_next = S_SQ;
      S_SQ:    if (step_reg == SW'(3)) state_next = S_CMP;
      S_CMP:   state_next = (d2_reg >= rs2_reg) ? S_OUT : S_SQRT;
      S_SQRT:  if (step_reg == SW'(W-1)) state_next = S_ZCHK;
      S_ZCHK:  state_next = (root_reg == '0) ? S_OUT : S_RECIP;
      S_RECIP: if (step_reg == SW'(W-1)) state_next = S_NORM;
      S_NORM:  if (step_reg == SW'(2)) state_next = S_POS;
      S_POS:   if (step_reg == SW'(2)) state_next = S_OUT;
      S_OUT:   if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst) begin
      state_reg     <= S_IDLE;
      step_reg      <= '0;
      out_valid_reg <= 1'b0;
      in_ready_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      step_reg      <= (state_next != state_reg) ? '0 : step_reg + SW'(1);
      out_valid_reg <= (state_next == S_OUT);
      in_ready_reg  <= (state_next == S_IDLE);
    end
  end

  always_ff @(posedge CLK_d or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 3; i++) begin
        p1_reg[i]  <= '0;
        p2_reg[i]  <= '0;
        nrm_reg[i] <= '0;
        pos_reg[i] <= '0;
      end
      for (int i = 0; i < 4; i++) dlt_reg[i] <= '0;
      r1_reg       <= '0;
      r2_reg       <= '0;
      rd_reg       <= '0;
      d2_reg       <= '0;
      rs2_reg      <= '0;
      rad_reg      <= '0;
      rem_reg      <= '0;
      root_reg     <= '0;
      dvr_reg      <= '0;
      dvn_reg      <= '0;
      inv_reg      <= '0;
      depth_reg    <= '0;
      ret_reg      <= 1'b0;
      out_tag_reg  <= '0;
      pair_cnt_reg <= '0;
      hit_cnt_reg  <= '0;
    end else begin
      case (state_reg)
        S_IDLE: if (in_valid && in_ready_reg) begin
          p1_reg[0]   <= x1;
          p1_reg[1]   <= y1;
          p1_reg[2]   <= z1;
          p2_reg[0]   <= x2;
          p2_reg[1]   <= y2;
          p2_reg[2]   <= z2;
          r1_reg      <= r1;
          r2_reg      <= r2;
          out_tag_reg <= in_tag;
        end
        S_DELTA: begin
          for (int i = 0; i < 3; i++)
            dlt_reg[i] <= (W+1)'(p1_reg[i]) - (W+1)'(p2_reg[i]);
          dlt_reg[3] <= (W+1)'(r1_reg) + (W+1)'(r2_reg);
          rd_reg     <= (W+1)'(r2_reg) - (W+1)'(r1_reg);
          d2_reg     <= '0;
        end
        S_SQ: begin
          if (idx == 2'd3) rs2_reg <= mul_p;
          else             d2_reg  <= d2_reg + mul_p;
        end
        S_CMP: begin
          if (d2_reg >= rs2_reg) begin
            ret_reg   <= 1'b0;
            depth_reg <= '0;
            for (int i = 0; i < 3; i++) begin
              nrm_reg[i] <= '0;
              pos_reg[i] <= '0;
            end
          end else begin
            rad_reg  <= d2_reg[2*W-1:0];
            rem_reg  <= '0;
            root_reg <= '0;
          end
        end
        S_SQRT: begin
          rad_reg  <= rad_reg << 2;
          rem_reg  <= W'(sq_ge ? sq_sh - sq_trial : sq_sh);
          root_reg <= {root_reg[W-2:0], sq_ge};
        end
        S_ZCHK: begin
          if (root_reg == '0) begin
            // Coincident centres: normal direction is arbitrary, pick +x
            for (int i = 0; i < 3; i++) pos_reg[i] <= p1_reg[i];
            nrm_reg[0] <= W'(1) << F;
            nrm_reg[1] <= '0;
            nrm_reg[2] <= '0;
            depth_reg  <= W'(dlt_reg[3]);
            ret_reg    <= 1'b1;
          end else begin
            dvr_reg <= DIV_N[2*W-1:W];
            dvn_reg <= DIV_N[W-1:0];
            inv_reg <= '0;
          end
        end
        S_RECIP: begin
          dvr_reg <= W'(dv_ge ? dv_sh - {1'b0, root_reg} : dv_sh);
          dvn_reg <= dvn_reg << 1;
          inv_reg <= {inv_reg[W-2:0], dv_ge};
        end
        S_NORM: nrm_reg[idx] <= mul_p[F+W-1:F];
        S_POS: begin
          if (CONTACT_MODE == 0)
            pos_reg[idx] <= p1_reg[idx] + mul_p[F+W-1:F];
          else
            pos_reg[idx] <= W'(((W+1)'(p1_reg[idx]) + (W+1)'(p2_reg[idx])) >>> 1);
          depth_reg <= W'(dlt_reg[3] - $signed({1'b0, root_reg}));
          ret_reg   <= 1'b1;
        end
        S_OUT: if (out_ready) begin
          if (pair_cnt_reg != '1) pair_cnt_reg <= pair_cnt_reg + CNT_W'(1);
          if (ret_reg && hit_cnt_reg != '1) hit_cnt_reg <= hit_cnt_reg + CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign out_tag   = out_tag_reg;
  assign ret       = ret_reg;
  assign cx        = pos_reg[0];
  assign cy        = pos_reg[1];
  assign cz        = pos_reg[2];
  assign normalx   = nrm_reg[0];
  assign normaly   = nrm_reg[1];
  assign normalz   = nrm_reg[2];
  assign depth     = depth_reg;
  assign busy      = (state_reg != S_IDLE);
  assign pair_cnt  = pair_cnt_reg;
  assign hit_cnt   = hit_cnt_reg;

endmodule

// File: tb/tb_dcollide_spheres_stream.sv
// Table-driven bench for dcollide_spheres_stream (W=32, F=16, mode 0) with
// hand-written back-pressure, mid-operation reset and streaming sequences.
module tb_dcollide_spheres_stream;

  logic        CLK_d = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] x1 = '0, y1 = '0, z1 = '0, r1 = '0;
  logic [31:0] x2 = '0, y2 = '0, z2 = '0, r2 = '0;
  logic [15:0] in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_tag;
  logic        ret;
  logic [31:0] cx, cy, cz, normalx, normaly, normalz, depth;
  logic        busy;
  logic [15:0] pair_cnt, hit_cnt;

  dcollide_spheres_stream #(
    .W(32), .F(16), .TAG_W(16), .CNT_W(16), .CONTACT_MODE(0)
  ) dut (
    .CLK_d(CLK_d), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .y1(y1), .z1(z1), .r1(r1),
    .x2(x2), .y2(y2), .z2(z2), .r2(r2),
    .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .ret(ret), .cx(cx), .cy(cy), .cz(cz),
    .normalx(normalx), .normaly(normaly), .normalz(normalz),
    .depth(depth), .busy(busy), .pair_cnt(pair_cnt), .hit_cnt(hit_cnt)
  );

  always #5 CLK_d = ~CLK_d;

  typedef struct {
    logic [31:0] x1, y1, z1, r1, x2, y2, z2, r2;
    logic [15:0] tag;
    logic        ret;
    logic [31:0] cx, cy, cz, nx, ny, nz, dep;
    int          lat;
    int          tol;
  } vec_t;

  vec_t tv [7];
  int   err_cnt = 0;
  int   chk_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input int tol);
    longint diff;
    chk_cnt++;
    diff = longint'($signed(act)) - longint'($signed(exp));
    if (diff > tol || diff < -tol) begin
      err_cnt++;
      $display("FAIL %s: got %h want %h (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic add(input int i,
                     input logic [31:0] ax1, ay1, az1, ar1, ax2, ay2, az2, ar2,
                     input logic [15:0] tag, input logic eret,
                     input logic [31:0] ecx, ecy, ecz, enx, eny, enz, edep,
                     input int lat, input int tol);
    tv[i].x1 = ax1; tv[i].y1 = ay1; tv[i].z1 = az1; tv[i].r1 = ar1;
    tv[i].x2 = ax2; tv[i].y2 = ay2; tv[i].z2 = az2; tv[i].r2 = ar2;
    tv[i].tag = tag; tv[i].ret = eret;
    tv[i].cx = ecx; tv[i].cy = ecy; tv[i].cz = ecz;
    tv[i].nx = enx; tv[i].ny = eny; tv[i].nz = enz;
    tv[i].dep = edep; tv[i].lat = lat; tv[i].tol = tol;
  endtask

  task automatic accept(input int i);
    int n = 0;
    @(negedge CLK_d);
    while (!in_ready && n < 200) begin
      @(negedge CLK_d);
      n++;
    end
    chk($sformatf("in_ready_wait[%0d]", i), {31'd0, in_ready}, 32'd1, 0);
    x1 = tv[i].x1; y1 = tv[i].y1; z1 = tv[i].z1; r1 = tv[i].r1;
    x2 = tv[i].x2; y2 = tv[i].y2; z2 = tv[i].z2; r2 = tv[i].r2;
    in_tag = tv[i].tag;
    in_valid = 1'b1;
    @(posedge CLK_d);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drive_junk();
    x1 = 32'h0007_0000; y1 = 32'hFFF9_0000; z1 = 32'h0003_8000; r1 = 32'h0004_0000;
    x2 = 32'h0001_0000; y2 = 32'h0002_0000; z2 = 32'hFFFE_0000; r2 = 32'h0005_0000;
    in_tag = 16'hDEAD;
    in_valid = 1'b1;
  endtask

  task automatic collect(input int i, input bit junk);
    int lat = 0;
    int t;
    if (junk) drive_junk();
    do begin
      @(posedge CLK_d);
      #1;
      lat++;
    end while (!out_valid && lat < 400);
    in_valid = 1'b0;
    t = tv[i].tol;
    chk($sformatf("lat[%0d]", i), lat, tv[i].lat, 0);
    chk($sformatf("ret[%0d]", i), {31'd0, ret}, {31'd0, tv[i].ret}, 0);
    chk($sformatf("tag[%0d]", i), {16'd0, out_tag}, {16'd0, tv[i].tag}, 0);
    chk($sformatf("cx[%0d]", i), cx, tv[i].cx, t);
    chk($sformatf("cy[%0d]", i), cy, tv[i].cy, t);
    chk($sformatf("cz[%0d]", i), cz, tv[i].cz, t);
    chk($sformatf("nx[%0d]", i), normalx, tv[i].nx, t);
    chk($sformatf("ny[%0d]", i), normaly, tv[i].ny, t);
    chk($sformatf("nz[%0d]", i), normalz, tv[i].nz, t);
    chk($sformatf("depth[%0d]", i), depth, tv[i].dep, t);
    $display("pair %0d tag=%h lat=%0d ret=%0d c=(%h,%h,%h) n=(%h,%h,%h) depth=%h",
             i, out_tag, lat, ret, cx, cy, cz, normalx, normaly, normalz, depth);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sidx [5];
    int seen;

    // Q16.16: 1.0 = 00010000
    add(0, 32'h0, 32'h0, 32'h0, 32'h10000, 32'h18000, 32'h0, 32'h0, 32'h10000, 16'h1111, 1'b1,
        32'hC000, 32'h0, 32'h0, 32'hFFFF0000, 32'h0, 32'h0, 32'h8000, 77, 2);
    add(1, 32'h0, 32'h0, 32'h0, 32'h10000, 32'h30000, 32'h0, 32'h0, 32'h10000, 16'h2222, 1'b0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6, 0);
    add(2, 32'h0, 32'h0, 32'h0, 32'h10000, 32'h20000, 32'h0, 32'h0, 32'h10000, 16'h3333, 1'b0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6, 0);
    add(3, 32'h10000, 32'h20000, 32'h30000, 32'h10000, 32'h10000, 32'h20000, 32'h30000, 32'h8000,
        16'h4444, 1'b1, 32'h10000, 32'h20000, 32'h30000, 32'h10000, 32'h0, 32'h0, 32'h18000, 39, 0);
    add(4, 32'h0, 32'h0, 32'h0, 32'h10000, 32'h0, 32'h10000, 32'h0, 32'h10000, 16'h5555, 1'b1,
        32'h0, 32'h8000, 32'h0, 32'h0, 32'hFFFF0000, 32'h0, 32'h10000, 77, 2);
    add(5, 32'h20000, 32'h50000, 32'hFFFD0000, 32'h18000, 32'h0, 32'h50000, 32'hFFFD0000, 32'h10000,
        16'h6666, 1'b1, 32'hC000, 32'h50000, 32'hFFFD0000, 32'h10000, 32'h0, 32'h0, 32'h8000, 77, 2);
    add(6, 32'h0, 32'h0, 32'hFFFC0000, 32'h10000, 32'h0, 32'h0, 32'h40000, 32'h10000, 16'h7777, 1'b0,
        32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 6, 0);

    repeat (3) @(posedge CLK_d);
    #1;
    chk("rst_ctrl", {28'd0, out_valid, in_ready, busy, ret}, 32'd0, 0);
    chk("rst_cx", cx, 32'd0, 0);
    chk("rst_normalx", normalx, 32'd0, 0);
    chk("rst_depth", depth, 32'd0, 0);
    chk("rst_cnt", {pair_cnt, hit_cnt}, 32'd0, 0);
    @(negedge CLK_d);
    rst = 1'b1;
    @(posedge CLK_d);
    #1;
    chk("in_ready_after_release", {31'd0, in_ready}, 32'd1, 0);

    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      accept(i);
      collect(i, 1'b1);
    end
    @(posedge CLK_d);
    #1;
    chk("table_pair_cnt", {16'd0, pair_cnt}, 32'd7, 0);
    chk("table_hit_cnt", {16'd0, hit_cnt}, 32'd4, 0);

    // Back-pressure: result must hold for 10 cycles and count exactly once
    out_ready = 1'b0;
    accept(4);
    collect(4, 1'b0);
    drive_junk();
    for (int k = 0; k < 10; k++) begin
      @(posedge CLK_d);
      #1;
      chk($sformatf("bp_valid[%0d]", k), {30'd0, out_valid, in_ready}, 32'd2, 0);
      chk($sformatf("bp_cy[%0d]", k), cy, 32'h8000, 2);
      chk($sformatf("bp_ny[%0d]", k), normaly, 32'hFFFF0000, 2);
      chk($sformatf("bp_tag[%0d]", k), {16'd0, out_tag}, 32'h5555, 0);
      chk($sformatf("bp_pair_cnt[%0d]", k), {16'd0, pair_cnt}, 32'd7, 0);
    end
    @(negedge CLK_d);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge CLK_d);
    #1;
    chk("bp_release_valid", {31'd0, out_valid}, 32'd0, 0);
    chk("bp_release_cnt", {pair_cnt, hit_cnt}, {16'd8, 16'd5}, 0);
    repeat (3) @(posedge CLK_d);
    #1;
    chk("bp_cnt_once", {pair_cnt, hit_cnt}, {16'd8, 16'd5}, 0);
    $display("backpressure pair_cnt=%0d hit_cnt=%0d", pair_cnt, hit_cnt);

    // Reset while the sqrt is running
    accept(0);
    repeat (20) @(posedge CLK_d);
    #1;
    chk("mid_busy", {31'd0, busy}, 32'd1, 0);
    @(negedge CLK_d);
    rst = 1'b0;
    #1;
    chk("mid_rst_ctrl", {28'd0, out_valid, in_ready, busy, ret}, 32'd0, 0);
    chk("mid_rst_cy", cy, 32'd0, 0);
    chk("mid_rst_normaly", normaly, 32'd0, 0);
    chk("mid_rst_depth", depth, 32'd0, 0);
    chk("mid_rst_tag", {16'd0, out_tag}, 32'd0, 0);
    chk("mid_rst_cnt", {pair_cnt, hit_cnt}, 32'd0, 0);
    repeat (2) @(negedge CLK_d);
    rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 90; k++) begin
      @(posedge CLK_d);
      #1;
      if (out_valid) seen++;
    end
    chk("aborted_no_valid", seen, 32'd0, 0);
    $display("reset during SQRT: stray out_valid cycles=%0d", seen);
    accept(5);
    collect(5, 1'b1);
    @(posedge CLK_d);
    #1;
    chk("post_rst_cnt", {pair_cnt, hit_cnt}, {16'd1, 16'd1}, 0);

    // Stream of 5 tagged pairs: 3 hits, 2 misses
    sidx[0] = 0; sidx[1] = 1; sidx[2] = 4; sidx[3] = 5; sidx[4] = 2;
    for (int s = 0; s < 5; s++) begin
      accept(sidx[s]);
      collect(sidx[s], 1'b0);
    end
    @(posedge CLK_d);
    #1;
    chk("stream_pair_cnt", {16'd0, pair_cnt}, 32'd6, 0);
    chk("stream_hit_cnt", {16'd0, hit_cnt}, 32'd4, 0);
    $display("stream pair_cnt=%0d hit_cnt=%0d", pair_cnt, hit_cnt);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
